// File: rtl/rtype_pkg.sv
// rtype_pkg: shared constants and types for the R-type decode/issue path.
// ALU select codes, R-type funct codes, the R-type opcode, the buffered
// entry layout and the writeback-forwarding helper.
package rtype_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;

   // ALU select codes
   localparam logic [3:0] SEL_AND  = 4'b0000;
   localparam logic [3:0] SEL_OR   = 4'b0001;
   localparam logic [3:0] SEL_ADD  = 4'b0010;
   localparam logic [3:0] SEL_SUB  = 4'b0011;
   localparam logic [3:0] SEL_SLT  = 4'b0100;
   localparam logic [3:0] SEL_SLL  = 4'b0101;
   localparam logic [3:0] SEL_SRL  = 4'b0110;
   localparam logic [3:0] SEL_SRA  = 4'b0111;
   localparam logic [3:0] SEL_XOR  = 4'b1001;
   localparam logic [3:0] SEL_NOR  = 4'b1010;
   localparam logic [3:0] SEL_SLLV = 4'b1100;
   localparam logic [3:0] SEL_SRLV = 4'b1101;
   localparam logic [3:0] SEL_SRAV = 4'b1110;
   localparam logic [3:0] SEL_NOP  = 4'b1111;

   // R-type funct codes
   localparam logic [5:0] F_SLL  = 6'b000000;
   localparam logic [5:0] F_SRL  = 6'b000010;
   localparam logic [5:0] F_SRA  = 6'b000011;
   localparam logic [5:0] F_SLLV = 6'b000100;
   localparam logic [5:0] F_SRLV = 6'b000110;
   localparam logic [5:0] F_SRAV = 6'b000111;
   localparam logic [5:0] F_ADD  = 6'b100000;
   localparam logic [5:0] F_ADDU = 6'b100001;
   localparam logic [5:0] F_SUB  = 6'b100010;
   localparam logic [5:0] F_SUBU = 6'b100011;
   localparam logic [5:0] F_AND  = 6'b100100;
   localparam logic [5:0] F_OR   = 6'b100101;
   localparam logic [5:0] F_XOR  = 6'b100110;
   localparam logic [5:0] F_NOR  = 6'b100111;
   localparam logic [5:0] F_SLT  = 6'b101010;

   typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_ONE = 2'd1, ST_TWO = 2'd2} buf_state_e;

   // One buffered instruction, operands already in ALU form
   typedef struct packed {
      logic [3:0]  sel;
      logic [4:0]  shamt;
      logic [31:0] d1;
      logic [31:0] d2;
      logic [4:0]  rd;
      logic        ill;
      logic        vsh;   // variable shift: d1 holds rs[4:0] only
      logic [4:0]  rs;
      logic [4:0]  rt;
   } entry_t;

   localparam entry_t ENTRY_RST = '{sel: SEL_NOP, default: '0};

   // Patch an entry's operands from the writeback bus; $0 never forwards,
   // illegal entries keep their zeroed operands.
   function automatic entry_t fwd_entry(entry_t e, logic wv, logic [4:0] wrd, logic [31:0] wd);
      entry_t r;
      r = e;
      if (wv && wrd != 5'd0 && !e.ill) begin
         if (e.rs == wrd) r.d1 = e.vsh ? {27'b0, wd[4:0]} : wd;
         if (e.rt == wrd) r.d2 = wd;
      end
      return r;
   endfunction

endpackage

// File: rtl/rtype_funct_dec.sv
// rtype_funct_dec: combinational R-type decoder, instruction word to ALU
// select, shamt source, variable-shift flag and illegal flag.
module rtype_funct_dec
   import rtype_pkg::*;
(
   input  logic [31:0] instr,
   output logic [3:0]  sel,
   output logic        shamt_sel,   // 1: shamt from instr[10:6]
   output logic        var_sh,
   output logic        illegal
);

   // Register index and shamt fields are consumed by the issue stage
   logic unused_bits;
   assign unused_bits = ^instr[25:6];

   // funct lookup, gated by the R-type opcode
   always_comb begin
      sel       = SEL_NOP;
      shamt_sel = 1'b0;
      var_sh    = 1'b0;
      illegal   = 1'b0;
      if (instr[31:26] != OP_RTYPE) begin
         illegal = 1'b1;
      end else begin
         case (instr[5:0])
            F_SLL:          begin sel = SEL_SLL;  shamt_sel = 1'b1; end
            F_SRL:          begin sel = SEL_SRL;  shamt_sel = 1'b1; end
            F_SRA:          begin sel = SEL_SRA;  shamt_sel = 1'b1; end
            F_SLLV:         begin sel = SEL_SLLV; var_sh = 1'b1; end
            F_SRLV:         begin sel = SEL_SRLV; var_sh = 1'b1; end
            F_SRAV:         begin sel = SEL_SRAV; var_sh = 1'b1; end
            F_ADD, F_ADDU:  sel = SEL_ADD;
            F_SUB, F_SUBU:  sel = SEL_SUB;
            F_AND:          sel = SEL_AND;
            F_OR:           sel = SEL_OR;
            F_XOR:          sel = SEL_XOR;
            F_NOR:          sel = SEL_NOR;
            F_SLT:          sel = SEL_SLT;
            default:        illegal = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/rtype_issue.sv
// rtype_issue: R-type decode/issue stage with a two-entry skid buffer
// feeding registered operands to the ALU.
// Optional feature: define RTYPE_ISSUE_FWD_EN to patch buffered and
// incoming operands from the writeback bus.
module rtype_issue
   import rtype_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_instr,
   input  logic [DW-1:0] in_rs_val,
   input  logic [DW-1:0] in_rt_val,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [3:0]    alu_sel,
   output logic [4:0]    alu_shamt,
   output logic [DW-1:0] alu_data_1,
   output logic [DW-1:0] alu_data_2,
   output logic [4:0]    out_rd,
   output logic          out_illegal,
   input  logic          wb_valid,
   input  logic [4:0]    wb_rd,
   input  logic [DW-1:0] wb_data
);

   buf_state_e state_q, state_d;
   entry_t     main_q, main_d, skid_q, skid_d;
   entry_t     new_e, new_f, main_f, skid_f;
   logic       in_ready_q, in_ready_d;
   logic [3:0] dec_sel;
   logic       dec_shamt_sel, dec_var_sh, dec_ill;
   logic       accept, consume;

   rtype_funct_dec u_dec (
      .instr     (in_instr),
      .sel       (dec_sel),
      .shamt_sel (dec_shamt_sel),
      .var_sh    (dec_var_sh),
      .illegal   (dec_ill)
   );

   // Build the incoming entry in ALU operand form
   always_comb begin
      new_e       = ENTRY_RST;
      new_e.sel   = dec_sel;
      new_e.rd    = in_instr[15:11];
      new_e.ill   = dec_ill;
      new_e.vsh   = dec_var_sh;
      new_e.rs    = in_instr[25:21];
      new_e.rt    = in_instr[20:16];
      if (!dec_ill) begin
         new_e.shamt = dec_shamt_sel ? in_instr[10:6] : 5'd0;
         new_e.d1    = dec_var_sh ? {27'b0, in_rs_val[4:0]} : in_rs_val;
         new_e.d2    = in_rt_val;
      end
   end

`ifdef RTYPE_ISSUE_FWD_EN
   assign new_f  = fwd_entry(new_e,  wb_valid, wb_rd, wb_data);
   assign main_f = fwd_entry(main_q, wb_valid, wb_rd, wb_data);
   assign skid_f = fwd_entry(skid_q, wb_valid, wb_rd, wb_data);
`else
   logic unused_fwd;
   assign unused_fwd = ^{wb_valid, wb_rd, wb_data, main_q.rs, main_q.rt, skid_q.rs, skid_q.rt};
   assign new_f  = new_e;
   assign main_f = main_q;
   assign skid_f = skid_q;
`endif

   assign accept  = in_valid && in_ready_q;
   assign consume = (state_q != ST_EMPTY) && out_ready;

   // Buffer next-state: main always drives the ALU, skid absorbs one stall
   always_comb begin
      state_d = state_q;
      main_d  = main_f;
      skid_d  = skid_f;
      case (state_q)
         ST_EMPTY: if (accept) begin
            main_d  = new_f;
            state_d = ST_ONE;
         end
         ST_ONE: begin
            if (accept && consume) begin
               main_d = new_f;
            end else if (accept) begin
               skid_d  = new_f;
               state_d = ST_TWO;
            end else if (consume) begin
               state_d = ST_EMPTY;
            end
         end
         ST_TWO: if (consume) begin
            main_d  = skid_f;
            state_d = ST_ONE;
         end
         default: state_d = ST_EMPTY;
      endcase
      in_ready_d = (state_d != ST_TWO);
   end

   // State and entry registers; reset drops both entries at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_EMPTY;
         main_q     <= ENTRY_RST;
         skid_q     <= ENTRY_RST;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
         in_ready_q <= in_ready_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = (state_q != ST_EMPTY);
   assign alu_sel     = main_q.sel;
   assign alu_shamt   = main_q.shamt;
   assign alu_data_1  = main_q.d1;
   assign alu_data_2  = main_q.d2;
   assign out_rd      = main_q.rd;
   assign out_illegal = main_q.ill;

endmodule

// File: tb/tb_rtype_issue.sv
// tb_rtype_issue: directed self-checking bench for rtype_issue.
// Forwarding expectations follow RTYPE_ISSUE_FWD_EN.
module tb_rtype_issue;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready;
   logic [31:0] in_instr, in_rs_val, in_rt_val;
   logic        out_valid, out_ready;
   logic [3:0]  alu_sel;
   logic [4:0]  alu_shamt;
   logic [31:0] alu_data_1, alu_data_2;
   logic [4:0]  out_rd;
   logic        out_illegal;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   int n_run  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   rtype_issue #(.DW(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
      .out_valid(out_valid), .out_ready(out_ready),
      .alu_sel(alu_sel), .alu_shamt(alu_shamt),
      .alu_data_1(alu_data_1), .alu_data_2(alu_data_2),
      .out_rd(out_rd), .out_illegal(out_illegal),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Offer one instruction, accept on the next edge, check at the following negedge
   task automatic issue1(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
      @(negedge clk);
      in_valid = 1'b1; in_instr = ins; in_rs_val = rs; in_rt_val = rt;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic chk_out(input string tag, input logic [3:0] sel, input logic [4:0] sh,
                          input logic [31:0] d1, input logic [31:0] d2, input logic ill);
      chk({tag, ".vld"},   32'(out_valid),   32'd1);
      chk({tag, ".sel"},   32'(alu_sel),     32'(sel));
      chk({tag, ".shamt"}, 32'(alu_shamt),   32'(sh));
      chk({tag, ".d1"},    alu_data_1,       d1);
      chk({tag, ".d2"},    alu_data_2,       d2);
      chk({tag, ".ill"},   32'(out_illegal), 32'(ill));
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_rs_val = '0; in_rt_val = '0;
      out_ready = 1'b1; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
      #12;
      // reset state
      chk("rst.vld",   32'(out_valid),   32'd0);
      chk("rst.rdy",   32'(in_ready),    32'd1);
      chk("rst.sel",   32'(alu_sel),     32'hF);
      chk("rst.shamt", 32'(alu_shamt),   32'd0);
      chk("rst.d1",    alu_data_1,       32'd0);
      chk("rst.d2",    alu_data_2,       32'd0);
      chk("rst.rd",    32'(out_rd),      32'd0);
      chk("rst.ill",   32'(out_illegal), 32'd0);
      rst_n = 1'b1;

      // add $3,$1,$2
      issue1(32'h00221820, 32'd5, 32'd7);
      chk_out("add", 4'b0010, 5'd0, 32'd5, 32'd7, 1'b0);
      chk("add.rd", 32'(out_rd), 32'd3);
      // sra $4,$2,4
      issue1(32'h00022103, 32'h11, 32'h80000000);
      chk_out("sra", 4'b0111, 5'd4, 32'h11, 32'h80000000, 1'b0);
      chk("sra.rd", 32'(out_rd), 32'd4);
      // srlv $3,$2,$1 : rs masked to 5 bits
      issue1(32'h00221806, 32'h23, 32'h1234);
      chk_out("srlv", 4'b1101, 5'd0, 32'd3, 32'h1234, 1'b0);
      // sllv with high rs bits set
      issue1(32'h00221804, 32'hFFFFFFE1, 32'h1);
      chk_out("sllv", 4'b1100, 5'd0, 32'd1, 32'h1, 1'b0);
      // subu, nor, slt
      issue1(32'h00221823, 32'd9, 32'd4);
      chk_out("subu", 4'b0011, 5'd0, 32'd9, 32'd4, 1'b0);
      issue1(32'h00221827, 32'hA, 32'hB);
      chk_out("nor", 4'b1010, 5'd0, 32'hA, 32'hB, 1'b0);
      issue1(32'h0022182A, 32'hC, 32'hD);
      chk_out("slt", 4'b0100, 5'd0, 32'hC, 32'hD, 1'b0);
      // addi: illegal opcode
      issue1(32'h20010005, 32'd5, 32'd7);
      chk_out("addi", 4'b1111, 5'd0, 32'd0, 32'd0, 1'b1);
      // R-type with unsupported funct 000001
      issue1(32'h00221841, 32'd5, 32'd7);
      chk_out("badf", 4'b1111, 5'd0, 32'd0, 32'd0, 1'b1);

      // back-pressure: three offers with out_ready low
      @(negedge clk);
      chk("bp.empty", 32'(out_valid), 32'd0);
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = 32'h00221820; in_rs_val = 32'd10; in_rt_val = 32'd1;
      @(negedge clk);
      chk("bp.rdy1", 32'(in_ready), 32'd1);
      chk("bp.selA", 32'(alu_sel), 32'h2);
      in_instr = 32'h00221822; in_rs_val = 32'd20; in_rt_val = 32'd2;
      @(negedge clk);
      chk("bp.rdy2", 32'(in_ready), 32'd0);
      chk("bp.holdA", alu_data_1, 32'd10);
      in_instr = 32'h00221824; in_rs_val = 32'd30; in_rt_val = 32'd3;
      @(negedge clk);
      chk("bp.rdy3", 32'(in_ready), 32'd0);
      chk("bp.stbS", 32'(alu_sel), 32'h2);
      chk("bp.stbD", alu_data_1, 32'd10);
      chk("bp.stbV", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp.selB", 32'(alu_sel), 32'h3);
      chk("bp.d1B", alu_data_1, 32'd20);
      chk("bp.rdyB", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      chk("bp.selC", 32'(alu_sel), 32'h0);
      chk("bp.d1C", alu_data_1, 32'd30);
      @(negedge clk);
      chk("bp.drain", 32'(out_valid), 32'd0);

      // writeback bus on a held 'and $7,$5,$6'
      out_ready = 1'b0;
      issue1(32'h00A63824, 32'h1234, 32'h55);
      wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF;
      @(negedge clk);
      chk("wb.r0", alu_data_1, 32'h1234);
      wb_rd = 5'd5;
      @(negedge clk);
`ifdef RTYPE_ISSUE_FWD_EN
      chk("wb.rs5", alu_data_1, 32'hFFFF);
`else
      chk("wb.rs5", alu_data_1, 32'h1234);
`endif
      chk("wb.rt", alu_data_2, 32'h55);
      wb_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("wb.drain", 32'(out_valid), 32'd0);

      // async reset while holding an entry
      out_ready = 1'b0;
      issue1(32'h00221820, 32'd1, 32'd2);
      #2 rst_n = 1'b0;
      #1;
      chk("arst.vld", 32'(out_valid), 32'd0);
      chk("arst.sel", 32'(alu_sel), 32'hF);
      rst_n = 1'b1;

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
